// File: rtl/cphy_hs_pkg.sv
// Shared C-PHY HS definitions used by the serializer and deserializer sides.
//   SYM_W / SYM_PER_WORD : symbol width and symbols per parallel word.
//   SYNC_WORD_DEFAULT    : HS sync pattern, 7 packed symbols, first-received in [2:0].
//   hsStateE             : deserializer state encoding.
//   symInvalid()         : flags symbol codes that no valid transition produces.
package cphy_hs_pkg;

  localparam int unsigned SYM_W        = 3;
  localparam int unsigned SYM_PER_WORD = 7;
  localparam int unsigned WORD_BITS    = SYM_W * SYM_PER_WORD;

  localparam logic [WORD_BITS-1:0] SYNC_WORD_DEFAULT = 21'o3444443;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } hsStateE;

  // Only codes 0..4 are legal {Flip, Rotation, Polarity} combinations.
  function automatic logic symInvalid(input logic [SYM_W-1:0] sym);
    return sym > 3'd4;
  endfunction

endpackage

// File: rtl/hs_sync_detector.sv
// HS sync word detector for the C-PHY receive path.
// Keeps the last 7 received symbols in a 21-bit shift register (newest at the top,
// oldest in [2:0]) and compares the post-shift value against SYNC_WORD.
// Ports:
//   RxSymbolClkHS  symbol clock, rising edge
//   Rst            synchronous active-high reset
//   Clr            synchronous clear (burst enable dropped)
//   ShiftEn        shift RxSym into the register this edge
//   DetEn          detection armed (hunting)
//   RxSym          received symbol
//   SyncHit        combinational: the symbol at this edge completes the sync word
//   RxSyncDet      registered one-cycle pulse following SyncHit
module hs_sync_detector
  import cphy_hs_pkg::*;
#(
  parameter logic [20:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic       RxSymbolClkHS,
  input  logic       Rst,
  input  logic       Clr,
  input  logic       ShiftEn,
  input  logic       DetEn,
  input  logic [2:0] RxSym,
  output logic       SyncHit,
  output logic       RxSyncDet
);

  logic [20:0] shiftQ;
  logic [20:0] shiftD;

  // Compare against the value the register will hold after this edge, so the
  // state machine can lock on the same edge that samples the last sync symbol.
  assign shiftD  = {RxSym, shiftQ[20:3]};
  assign SyncHit = DetEn && ShiftEn && (shiftD == SYNC_WORD);

  always_ff @(posedge RxSymbolClkHS) begin
    if (Rst || Clr) begin
      shiftQ    <= '0;
      RxSyncDet <= 1'b0;
    end else begin
      if (ShiftEn) begin
        shiftQ <= shiftD;
      end
      RxSyncDet <= SyncHit;
    end
  end

endmodule

// File: rtl/hs_deserializer.sv
// C-PHY HS deserializer: hunts for the HS sync word, then packs each following
// group of 7 symbols into three 7-bit words (first symbol in bit 0).
// Optional feature macro: HS_DESER_SYMERR_EN enables the invalid-symbol flag;
// without it RxSymErr is tied to 0.
// Ports:
//   RxSymbolClkHS     symbol clock, rising edge
//   Rst               synchronous active-high reset
//   HsDeserializerEn  burst enable, high for the whole HS burst
//   RxSym             symbol {Flip, Rotation, Polarity}
//   RxFlip/RxRotation/RxPolarity  assembled words, hold between strobes
//   RxWordValid       one-cycle strobe for new words
//   RxLocked          sync found, alignment fixed
//   RxSyncDet         one-cycle pulse on sync detection
//   RxSymErr          group contained an invalid symbol (with RxWordValid only)
module hs_deserializer
  import cphy_hs_pkg::*;
#(
  parameter logic [20:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic       RxSymbolClkHS,
  input  logic       Rst,
  input  logic       HsDeserializerEn,
  input  logic [2:0] RxSym,
  output logic [6:0] RxFlip,
  output logic [6:0] RxRotation,
  output logic [6:0] RxPolarity,
  output logic       RxWordValid,
  output logic       RxLocked,
  output logic       RxSyncDet,
  output logic       RxSymErr
);

  hsStateE    state;
  logic [2:0] symCnt;
  // Bit 6 of each word is taken straight from RxSym on the closing edge.
  logic [5:0] flipHold;
  logic [5:0] rotHold;
  logic [5:0] polHold;
  logic       shiftEn;
  logic       detEn;
  logic       syncHit;
  logic       lastSym;
  logic       clrBurst;

  assign clrBurst = !HsDeserializerEn;
  assign shiftEn  = HsDeserializerEn && (state != LOCKED);
  assign detEn    = (state == HUNT);
  assign lastSym  = (symCnt == 3'(SYM_PER_WORD - 1));

  hs_sync_detector #(
    .SYNC_WORD(SYNC_WORD)
  ) u_sync_detector (
    .RxSymbolClkHS(RxSymbolClkHS),
    .Rst          (Rst),
    .Clr          (clrBurst),
    .ShiftEn      (shiftEn),
    .DetEn        (detEn),
    .RxSym        (RxSym),
    .SyncHit      (syncHit),
    .RxSyncDet    (RxSyncDet)
  );

  always_ff @(posedge RxSymbolClkHS) begin
    if (Rst || clrBurst) begin
      // Any partial group is dropped; hunting restarts from an empty register.
      state       <= IDLE;
      symCnt      <= '0;
      flipHold    <= '0;
      rotHold     <= '0;
      polHold     <= '0;
      RxFlip      <= '0;
      RxRotation  <= '0;
      RxPolarity  <= '0;
      RxWordValid <= 1'b0;
      RxLocked    <= 1'b0;
    end else begin
      RxWordValid <= 1'b0;
      case (state)
        IDLE: begin
          state <= HUNT;
        end
        HUNT: begin
          if (syncHit) begin
            state    <= LOCKED;
            RxLocked <= 1'b1;
            symCnt   <= '0;
          end
        end
        LOCKED: begin
          if (lastSym) begin
            RxFlip      <= {RxSym[2], flipHold};
            RxRotation  <= {RxSym[1], rotHold};
            RxPolarity  <= {RxSym[0], polHold};
            RxWordValid <= 1'b1;
            symCnt      <= '0;
          end else begin
            flipHold[symCnt] <= RxSym[2];
            rotHold[symCnt]  <= RxSym[1];
            polHold[symCnt]  <= RxSym[0];
            symCnt           <= symCnt + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef HS_DESER_SYMERR_EN
  logic errAcc;
  logic symErrQ;

  always_ff @(posedge RxSymbolClkHS) begin
    if (Rst || clrBurst) begin
      errAcc  <= 1'b0;
      symErrQ <= 1'b0;
    end else begin
      symErrQ <= 1'b0;
      if (state == LOCKED) begin
        if (lastSym) begin
          symErrQ <= errAcc | symInvalid(RxSym);
          errAcc  <= 1'b0;
        end else begin
          errAcc <= errAcc | symInvalid(RxSym);
        end
      end else begin
        errAcc <= 1'b0;
      end
    end
  end

  assign RxSymErr = symErrQ;
`else
  assign RxSymErr = 1'b0;
`endif

endmodule

// File: tb/tb_hs_deserializer.sv
// Scoreboard bench for hs_deserializer. The driver feeds a symbol-stream reference
// model that pushes per-cycle expectations and expected words into queues; a
// separate monitor pops and compares them one cycle-sample after each rising edge.
module tb_hs_deserializer;

  logic       clk = 1'b0;
  logic       Rst;
  logic       En;
  logic [2:0] RxSym;
  logic [6:0] RxFlip;
  logic [6:0] RxRotation;
  logic [6:0] RxPolarity;
  logic       RxWordValid;
  logic       RxLocked;
  logic       RxSyncDet;
  logic       RxSymErr;

  always #5 clk = ~clk;

  hs_deserializer dut (
    .RxSymbolClkHS   (clk),
    .Rst             (Rst),
    .HsDeserializerEn(En),
    .RxSym           (RxSym),
    .RxFlip          (RxFlip),
    .RxRotation      (RxRotation),
    .RxPolarity      (RxPolarity),
    .RxWordValid     (RxWordValid),
    .RxLocked        (RxLocked),
    .RxSyncDet       (RxSyncDet),
    .RxSymErr        (RxSymErr)
  );

  localparam logic [20:0] SyncRef = 21'o3444443;

  typedef struct packed {
    logic       locked;
    logic       syncDet;
    logic       valid;
    logic       err;
    logic [6:0] flip;
    logic [6:0] rot;
    logic [6:0] pol;
  } lvlT;

  typedef struct packed {
    logic [6:0] flip;
    logic [6:0] rot;
    logic [6:0] pol;
    logic       err;
  } wordT;

  lvlT        levelQ[$];
  wordT       wordQ[$];
  int         nAssert = 0;
  int         nFail   = 0;
  logic [6:0] lastFlip = '0;
  logic [6:0] lastRot  = '0;
  logic [6:0] lastPol  = '0;

  // Reference model state: a stream view of the burst.
  logic [2:0] hist[$];
  logic [2:0] grp[$];
  bit         mLocked = 1'b0;
  logic [6:0] mFlip = '0;
  logic [6:0] mRot  = '0;
  logic [6:0] mPol  = '0;

  function automatic bit histIsSync();
    logic [20:0] sw;
    sw = SyncRef;
    for (int i = 0; i < 7; i++) begin
      if (hist[i] != sw[3*i +: 3]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model(input bit r, input bit e, input logic [2:0] s);
    lvlT  l;
    wordT w;
    l = '0;
    if (r || !e) begin
      hist.delete();
      grp.delete();
      mLocked = 1'b0;
      mFlip = '0;
      mRot  = '0;
      mPol  = '0;
    end else if (!mLocked) begin
      hist.push_back(s);
      if (hist.size() > 7) void'(hist.pop_front());
      if (hist.size() == 7 && histIsSync()) begin
        mLocked   = 1'b1;
        l.syncDet = 1'b1;
        grp.delete();
      end
    end else begin
      grp.push_back(s);
      if (grp.size() == 7) begin
        w = '0;
        for (int i = 0; i < 7; i++) begin
          mFlip[i] = grp[i][2];
          mRot[i]  = grp[i][1];
          mPol[i]  = grp[i][0];
`ifdef HS_DESER_SYMERR_EN
          if (grp[i] > 3'd4) w.err = 1'b1;
`endif
        end
        w.flip = mFlip;
        w.rot  = mRot;
        w.pol  = mPol;
        wordQ.push_back(w);
        l.valid = 1'b1;
        l.err   = w.err;
        grp.delete();
      end
    end
    l.locked = mLocked;
    l.flip   = mFlip;
    l.rot    = mRot;
    l.pol    = mPol;
    levelQ.push_back(l);
  endtask

  // Monitor: sample 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (levelQ.size() > 0) begin
        lvlT  e;
        lvlT  a;
        wordT w;
        wordT g;
        e = levelQ.pop_front();
        a = {RxLocked, RxSyncDet, RxWordValid, RxSymErr, RxFlip, RxRotation, RxPolarity};
        nAssert++;
        if (a !== e) begin
          nFail++;
          $display("FAIL cycle-state t=%0t actual lock/sync/valid/err=%b%b%b%b f/r/p=%h/%h/%h required lock/sync/valid/err=%b%b%b%b f/r/p=%h/%h/%h",
                   $time, a.locked, a.syncDet, a.valid, a.err, a.flip, a.rot, a.pol,
                   e.locked, e.syncDet, e.valid, e.err, e.flip, e.rot, e.pol);
        end
        if (RxWordValid === 1'b1) begin
          nAssert++;
          if (wordQ.size() == 0) begin
            nFail++;
            $display("FAIL word-strobe t=%0t actual strobe with no word expected required none",
                     $time);
          end else begin
            w = wordQ.pop_front();
            g = {RxFlip, RxRotation, RxPolarity, RxSymErr};
            if (g !== w) begin
              nFail++;
              $display("FAIL word-data t=%0t actual f/r/p/err=%b/%b/%b/%b required %b/%b/%b/%b",
                       $time, g.flip, g.rot, g.pol, g.err, w.flip, w.rot, w.pol, w.err);
            end
            lastFlip = RxFlip;
            lastRot  = RxRotation;
            lastPol  = RxPolarity;
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit e, input logic [2:0] s);
    @(negedge clk);
    Rst   = r;
    En    = e;
    RxSym = s;
    model(r, e, s);
  endtask

  task automatic sendSync();
    logic [20:0] sw;
    sw = SyncRef;
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, sw[3*i +: 3]);
  endtask

  // Serializer-side model: bit i of each word forms symbol i.
  task automatic sendWord(input logic [6:0] f, input logic [6:0] r, input logic [6:0] p);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, {f[i], r[i], p[i]});
  endtask

  task automatic sendRand(input int n, input int unsigned maxv);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 3'($urandom_range(maxv, 0)));
  endtask

  task automatic sendRandWord();
    sendWord(7'($urandom), 7'($urandom), 7'($urandom));
  endtask

  initial begin
    logic [2:0] dir[7];
    int         badPos;
    Rst   = 1'b1;
    En    = 1'b0;
    RxSym = 3'd0;
    dir   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};

    // Reset with arbitrary inputs, then zeros with enable held.
    repeat (3) step(1'b1, 1'($urandom), 3'($urandom));
    repeat (20) step(1'b0, 1'b1, 3'd0);

    // Directed sync plus first group.
    sendSync();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, dir[i]);
    step(1'b0, 1'b1, 3'd0);
    nAssert++;
    if ({lastFlip, lastRot, lastPol} !== {7'b0001000, 7'b1000110, 7'b0100101}) begin
      nFail++;
      $display("FAIL directed-word actual f/r/p=%b/%b/%b required 0001000/1000110/0100101",
               lastFlip, lastRot, lastPol);
    end

    // Loopback: random lead-in, sync, three serialized groups.
    step(1'b0, 1'b0, 3'd0);
    sendRand(5, 7);
    sendSync();
    repeat (3) sendRandWord();

    // Enable drop four symbols into a group, then recover.
    sendRand(4, 7);
    step(1'b0, 1'b0, 3'($urandom));
    step(1'b0, 1'b0, 3'($urandom));
    sendSync();
    sendRandWord();

    // Reset mid-group with enable still high.
    sendRand(3, 7);
    step(1'b1, 1'b1, 3'($urandom));
    sendRand(10, 3);
    sendSync();
    sendRandWord();

    // Group with an invalid symbol, then a clean group.
    badPos = int'($urandom_range(6, 0));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, (i == badPos) ? 3'd6 : 3'($urandom_range(4, 0)));
    end
    sendRand(7, 4);

    // Random soak with occasional injected sync words and enable drops.
    for (int k = 0; k < 400; k++) begin
      bit r;
      bit e;
      r = ($urandom_range(99, 0) == 0);
      e = ($urandom_range(39, 0) != 0);
      if (!r && e && $urandom_range(24, 0) == 0) sendSync();
      else step(r, e, 3'($urandom));
    end

    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    @(posedge clk);
    #2;
    nAssert++;
    if (wordQ.size() != 0 || levelQ.size() != 0) begin
      nFail++;
      $display("FAIL scoreboard-drain actual words=%0d levels=%0d left required 0/0",
               wordQ.size(), levelQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
